// File: rtl/hdmi_packet_pkg.sv
// Shared types, constants and the BCH step function for HDMI data-island packets.
package hdmi_packet_pkg;

  localparam logic [7:0] SPD_HB0  = 8'h83;
  localparam logic [7:0] BCH_POLY = 8'h83;

  typedef logic [23:0] packet_header_t;
  typedef logic [55:0] subpacket_t;

  typedef enum logic {ColIdle, ColCollect} col_state_e;
  typedef enum logic [1:0] {CkIdle, CkSum, CkDone} ck_state_e;

  // One serial BCH step: shift right, fold the polynomial in when the output bit differs from d.
  function automatic logic [7:0] next_ecc(input logic [7:0] ecc, input logic d);
    return (ecc >> 1) ^ ((ecc[0] ^ d) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/packet_ecc_lfsr.sv
// 8-bit BCH LFSR advancing one or two data bits per clock; clear restarts from zero.
module packet_ecc_lfsr
  import hdmi_packet_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       two_i,
  input  logic [1:0] d_i,
  output logic [7:0] ecc_o
);

  logic [7:0] ecc_q, ecc_d;
  logic [7:0] base, step1;

  // Clear with enable folds the first bit into a zero seed, so clock 0 data is not lost.
  always_comb begin
    base  = clr_i ? 8'h00 : ecc_q;
    step1 = next_ecc(base, d_i[0]);
    ecc_d = ecc_q;
    if (en_i) begin
      ecc_d = two_i ? next_ecc(step1, d_i[1]) : step1;
    end else if (clr_i) begin
      ecc_d = 8'h00;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ecc_q <= 8'h00;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc_o = ecc_q;

endmodule

// File: rtl/spd_info_frame_receiver.sv
// SPD InfoFrame sink: collects 32-clock data-island packets, checks BCH ECC, header and
// checksum, and publishes vendor name, product description and source device info.
module spd_info_frame_receiver
  import hdmi_packet_pkg::*;
#(
  parameter bit         CHECK_ECC        = 1'b1,
  parameter logic [7:0] EXPECTED_VERSION = 8'd1,
  parameter logic [4:0] EXPECTED_LENGTH  = 5'd25
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         island_valid,
  input  logic         packet_start,
  input  logic         header_bit,
  input  logic [7:0]   sub_bits,
  output logic [63:0]  vendor_name,
  output logic [127:0] product_description,
  output logic [7:0]   source_device_information,
  output logic         spd_present,
  output logic         spd_update,
  output logic         ecc_error,
  output logic         checksum_error,
  output logic         overrun
);

  // ---------------------------------------------------------------- collector
  col_state_e col_state_q, col_state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] k;
  logic       take, complete, lfsr_clr, hdr_en, sub_en;

  packet_header_t        hdr_q, hdr_d;
  logic [7:0]            hdr_rx_q, hdr_rx_d;
  subpacket_t [3:0]      sp_q, sp_d;
  logic [3:0][7:0]       sp_rx_q, sp_rx_d;
  logic [7:0]            hdr_ecc;
  logic [3:0][7:0]       sp_ecc;

  // Decode which packet clock (k) this cycle carries; packet_start always restarts at 0.
  always_comb begin
    take     = island_valid && (packet_start || (col_state_q == ColCollect));
    k        = packet_start ? 5'd0 : cnt_q;
    complete = take && (k == 5'd31);
    lfsr_clr = take && (k == 5'd0);
    hdr_en   = take && (k < 5'd24);
    sub_en   = take && (k < 5'd28);
  end

  // Collector state register.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      col_state_q <= ColIdle;
      cnt_q       <= 5'd0;
    end else begin
      col_state_q <= col_state_d;
      cnt_q       <= cnt_d;
    end
  end

  // Collector next state: counter wraps 31 -> 0 on completion; a gap in island_valid aborts.
  always_comb begin
    col_state_d = col_state_q;
    cnt_d       = cnt_q;
    if (take) begin
      cnt_d       = k + 5'd1;
      col_state_d = complete ? ColIdle : ColCollect;
    end else if (!island_valid) begin
      col_state_d = ColIdle;
    end
  end

  // Collector outputs: route each clock's bits to data or received-ECC positions.
  always_comb begin
    hdr_d    = hdr_q;
    hdr_rx_d = hdr_rx_q;
    sp_d     = sp_q;
    sp_rx_d  = sp_rx_q;
    if (take) begin
      if (k < 5'd24) begin
        hdr_d[k] = header_bit;
      end else begin
        hdr_rx_d[k[2:0]] = header_bit;
      end
      for (int i = 0; i < 4; i++) begin
        if (k < 5'd28) begin
          sp_d[i][{k, 1'b0}] = sub_bits[2*i];
          sp_d[i][{k, 1'b1}] = sub_bits[2*i+1];
        end else begin
          sp_rx_d[i][{k[1:0], 1'b0}] = sub_bits[2*i];
          sp_rx_d[i][{k[1:0], 1'b1}] = sub_bits[2*i+1];
        end
      end
    end
  end

  // Packet data and received ECC capture.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q    <= '0;
      hdr_rx_q <= '0;
      sp_q     <= '0;
      sp_rx_q  <= '0;
    end else begin
      hdr_q    <= hdr_d;
      hdr_rx_q <= hdr_rx_d;
      sp_q     <= sp_d;
      sp_rx_q  <= sp_rx_d;
    end
  end

  packet_ecc_lfsr u_hdr_ecc (
    .clk_i  (clk_pixel),
    .rst_ni (reset_n),
    .clr_i  (lfsr_clr),
    .en_i   (hdr_en),
    .two_i  (1'b0),
    .d_i    ({1'b0, header_bit}),
    .ecc_o  (hdr_ecc)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sub_ecc
    packet_ecc_lfsr u_sub_ecc (
      .clk_i  (clk_pixel),
      .rst_ni (reset_n),
      .clr_i  (lfsr_clr),
      .en_i   (sub_en),
      .two_i  (1'b1),
      .d_i    (sub_bits[2*i+1 -: 2]),
      .ecc_o  (sp_ecc[i])
    );
  end

  // ---------------------------------------------------------------- shadow / handoff
  packet_header_t   hdr_sh_q;
  subpacket_t [3:0] sp_sh_q;
  logic             load_q, load_d, ck_busy, ecc_bad;

  assign load_d = complete && !ck_busy;

  // Shadow copy of a finished packet; load_q marks the cycle the checker sees it.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      load_q   <= 1'b0;
      hdr_sh_q <= '0;
      sp_sh_q  <= '0;
    end else begin
      load_q <= load_d;
      if (load_d) begin
        hdr_sh_q <= hdr_q;
        sp_sh_q  <= sp_q;
      end
    end
  end

  // LFSRs and received ECC still hold the finished packet during load_q: a following
  // packet's clock 0 only takes effect at the end of that cycle.
  assign ecc_bad = (hdr_ecc != hdr_rx_q) || (sp_ecc != sp_rx_q);

  // ---------------------------------------------------------------- checker
  ck_state_e    ck_state_q, ck_state_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   sum_q, sum_d, sum_next, cur_byte;
  logic [247:0] pkt_bytes;
  logic         header_ok, pkt_accept, last_byte;
  logic [63:0]  vendor_new;
  logic [127:0] pd_new;
  logic [7:0]   sdi_new;

  // Byte n of the packet: HB0..HB2 then PB0..PB27.
  assign pkt_bytes  = {sp_sh_q, hdr_sh_q};
  assign cur_byte   = pkt_bytes[{idx_q, 3'b000} +: 8];
  assign sum_next   = sum_q + cur_byte;
  assign header_ok  = (hdr_sh_q[7:0] == SPD_HB0) && (hdr_sh_q[15:8] == EXPECTED_VERSION) &&
                      (hdr_sh_q[20:16] == EXPECTED_LENGTH);
  assign pkt_accept = header_ok && !(CHECK_ECC && ecc_bad);
  assign last_byte  = (ck_state_q == CkSum) && (idx_q == 5'd30);
  // The last summing cycle no longer needs the shadow, so back-to-back packets hand off cleanly.
  assign ck_busy    = load_q || ((ck_state_q == CkSum) && (idx_q != 5'd30));

  for (genvar n = 0; n < 8; n++) begin : g_vendor
    assign vendor_new[8*(7-n) +: 8] = pkt_bytes[8*(4+n) +: 8];
  end
  for (genvar n = 0; n < 16; n++) begin : g_product
    assign pd_new[8*(15-n) +: 8] = pkt_bytes[8*(12+n) +: 8];
  end
  assign sdi_new = pkt_bytes[8*28 +: 8];

  // Checker state register.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      ck_state_q <= CkIdle;
      idx_q      <= 5'd0;
      sum_q      <= 8'h00;
    end else begin
      ck_state_q <= ck_state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
    end
  end

  // Checker next state: CK_DONE behaves as idle so a new load is never missed.
  always_comb begin
    ck_state_d = ck_state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    unique case (ck_state_q)
      CkSum: begin
        sum_d = sum_next;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd30) ck_state_d = CkDone;
      end
      default: begin
        ck_state_d = CkIdle;
        if (load_q && pkt_accept) begin
          ck_state_d = CkSum;
          idx_d      = 5'd0;
          sum_d      = 8'h00;
        end
      end
    endcase
  end

  logic         spd_update_d, checksum_error_d, ecc_error_d, overrun_d;
  logic         spd_update_q, checksum_error_q, ecc_error_q, overrun_q, spd_present_q;
  logic [63:0]  vendor_q;
  logic [127:0] pd_q;
  logic [7:0]   sdi_q;

  // Checker outputs: results are registered so they appear during CK_DONE.
  always_comb begin
    spd_update_d     = last_byte && (sum_next == 8'h00);
    checksum_error_d = last_byte && (sum_next != 8'h00);
    ecc_error_d      = load_q && ecc_bad;
    overrun_d        = complete && ck_busy;
  end

  // Published fields and status pulses.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      spd_update_q     <= 1'b0;
      checksum_error_q <= 1'b0;
      ecc_error_q      <= 1'b0;
      overrun_q        <= 1'b0;
      spd_present_q    <= 1'b0;
      vendor_q         <= '0;
      pd_q             <= '0;
      sdi_q            <= '0;
    end else begin
      spd_update_q     <= spd_update_d;
      checksum_error_q <= checksum_error_d;
      ecc_error_q      <= ecc_error_d;
      overrun_q        <= overrun_d;
      if (spd_update_d) begin
        spd_present_q <= 1'b1;
        vendor_q      <= vendor_new;
        pd_q          <= pd_new;
        sdi_q         <= sdi_new;
      end
    end
  end

  assign vendor_name               = vendor_q;
  assign product_description       = pd_q;
  assign source_device_information = sdi_q;
  assign spd_present               = spd_present_q;
  assign spd_update                = spd_update_q;
  assign ecc_error                 = ecc_error_q;
  assign checksum_error            = checksum_error_q;
  assign overrun                   = overrun_q;

endmodule
